// File: rtl/hs_stream_source_pkg.sv
// Shared handshake constants and types for the req/ack stream responder and its FIFO.
package hs_stream_source_pkg;

   localparam int unsigned ACK_PULSE = 1;
   localparam int unsigned COUNT_W   = 32;

   typedef enum logic [0:0] {StIdle, StAck} resp_state_e;

   // Pointer width: one extra MSB beyond the address distinguishes full from empty.
   function automatic int unsigned ptr_width(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/hs_stream_source_if.sv
// Upstream valid/ready stream plus downstream req/ack/data lines of the stream source.
interface hs_stream_source_if #(
   parameter int unsigned data_width = 32
);
   logic                  s_valid;
   logic                  s_ready;
   logic [data_width-1:0] s_data;
   logic                  req;
   logic                  ack;
   logic [data_width-1:0] dout;

   modport master (
      output s_valid, s_data, req,
      input  s_ready, ack, dout
   );

   modport slave (
      input  s_valid, s_data, req,
      output s_ready, ack, dout
   );
endinterface

// File: rtl/hs_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers, occupancy level and synchronous flush.
module hs_sync_fifo
   import hs_stream_source_pkg::*;
#(
   parameter  int unsigned data_width = 32,
   parameter  int unsigned depth      = 8,
   localparam int unsigned PtrW       = ptr_width(depth)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  push,
   input  logic                  pop,
   input  logic [data_width-1:0] wdata,
   output logic [data_width-1:0] rdata,
   output logic                  full,
   output logic                  empty,
   output logic [PtrW-1:0]       level
);
   localparam int unsigned AddrW = PtrW - 1;

   logic [data_width-1:0] mem [depth];
   logic [PtrW-1:0]       wr_q, rd_q;
   logic                  push_en, pop_en;

   // Flush wins over both ports; a word offered alongside flush is dropped.
   assign push_en = push & ~full & ~flush;
   assign pop_en  = pop & ~empty & ~flush;

   assign full  = (wr_q[AddrW] != rd_q[AddrW]) && (wr_q[AddrW-1:0] == rd_q[AddrW-1:0]);
   assign empty = (wr_q == rd_q);
   assign level = wr_q - rd_q;
   assign rdata = mem[rd_q[AddrW-1:0]];

   always_ff @(posedge clk) begin
      if (push_en) begin
         mem[wr_q[AddrW-1:0]] <= wdata;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_q <= '0;
         rd_q <= '0;
      end else if (flush) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         if (push_en) wr_q <= wr_q + 1'b1;
         if (pop_en)  rd_q <= rd_q + 1'b1;
      end
   end

endmodule

// File: rtl/hs_stream_source.sv
// Responder end of the req/ack handshake: FIFO-buffered stream words returned as ack + dout.
module hs_stream_source
   import hs_stream_source_pkg::*;
#(
   parameter  int unsigned           data_width    = 32,
   parameter  int unsigned           depth         = 8,
   parameter  logic [data_width-1:0] initial_value = '0,
   localparam int unsigned           LevelW        = ptr_width(depth)
) (
   input  logic               clk,
   input  logic               rst,
   hs_stream_source_if.slave  bus,
   input  logic               flush,
   output logic [LevelW-1:0]  level,
   output logic [COUNT_W-1:0] count
);
   resp_state_e           state_q, state_d;
   logic [data_width-1:0] dout_q;
   logic [COUNT_W-1:0]    count_q;
   logic [data_width-1:0] rdata;
   logic                  full, empty, push, pop;

   assign push = bus.s_valid & ~full;

   hs_sync_fifo #(
      .data_width (data_width),
      .depth      (depth)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .push  (push),
      .pop   (pop),
      .wdata (bus.s_data),
      .rdata (rdata),
      .full  (full),
      .empty (empty),
      .level (level)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Ack lasts exactly one cycle, so a pop is only allowed from idle; max rate 1 word / 2 cycles.
   always_comb begin
      state_d = StIdle;
      pop     = 1'b0;
      if (!flush && bus.req && (state_q == StIdle) && !empty) begin
         state_d = StAck;
         pop     = 1'b1;
      end
   end

   always_comb begin
      bus.ack     = (state_q == StAck);
      bus.s_ready = ~full;
      bus.dout    = dout_q;
      count       = count_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dout_q  <= initial_value;
         count_q <= '0;
      end else if (flush) begin
         dout_q  <= initial_value;
         count_q <= '0;
      end else if (pop) begin
         dout_q  <= rdata;
         count_q <= count_q + 1'b1;
      end
   end

endmodule

// File: tb/tb_hs_stream_source.sv
// Directed bench for hs_stream_source: reset, latency, throughput, full, empty-req, flush.
module tb_hs_stream_source;
   import hs_stream_source_pkg::*;

   localparam int unsigned    DW   = 32;
   localparam int unsigned    DEP  = 8;
   localparam logic [DW-1:0]  INIT = 32'h0000_00C3;

   logic              clk;
   logic              rst;
   logic              flush;
   logic [3:0]        level;
   logic [COUNT_W-1:0] count;
   int                n_checks;
   int                n_fail;

   hs_stream_source_if #(.data_width(DW)) bus ();

   hs_stream_source #(
      .data_width    (DW),
      .depth         (DEP),
      .initial_value (INIT)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .bus   (bus),
      .flush (flush),
      .level (level),
      .count (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      n_checks++; if (bus.ack !== 1'b0) begin n_fail++; $display("FAIL rst_ack got %0h want 0", bus.ack); end
      n_checks++; if (bus.dout !== INIT) begin n_fail++; $display("FAIL rst_dout got %0h want %0h", bus.dout, INIT); end
      n_checks++; if (level !== 4'd0) begin n_fail++; $display("FAIL rst_level got %0d want 0", level); end
      n_checks++; if (count !== 32'd0) begin n_fail++; $display("FAIL rst_count got %0d want 0", count); end
      n_checks++; if (bus.s_ready !== 1'b1) begin n_fail++; $display("FAIL rst_sready got %0h want 1", bus.s_ready); end
      // Mid-transfer: two pushes, first one acked, then async reset.
      bus.req = 1'b1; bus.s_valid = 1'b1; bus.s_data = 32'h11;
      tick();
      bus.s_data = 32'h22;
      tick();
      bus.s_valid = 1'b0;
      n_checks++; if (bus.ack !== 1'b1) begin n_fail++; $display("FAIL pre_rst_ack got %0h want 1", bus.ack); end
      n_checks++; if (level !== 4'd1) begin n_fail++; $display("FAIL pre_rst_level got %0d want 1", level); end
      #2 rst = 1'b0;
      #1;
      n_checks++; if (bus.ack !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ack got %0h want 0", bus.ack); end
      n_checks++; if (bus.dout !== INIT) begin n_fail++; $display("FAIL mid_rst_dout got %0h want %0h", bus.dout, INIT); end
      n_checks++; if (level !== 4'd0) begin n_fail++; $display("FAIL mid_rst_level got %0d want 0", level); end
      n_checks++; if (count !== 32'd0) begin n_fail++; $display("FAIL mid_rst_count got %0d want 0", count); end
      bus.req = 1'b0;
      #2 rst = 1'b1;
      tick();
   endtask

   task automatic test_latency();
      bus.req = 1'b1; bus.s_valid = 1'b1; bus.s_data = 32'h5;
      tick();
      bus.s_valid = 1'b0;
      n_checks++; if (bus.ack !== 1'b0) begin n_fail++; $display("FAIL lat_nobypass got %0h want 0", bus.ack); end
      n_checks++; if (level !== 4'd1) begin n_fail++; $display("FAIL lat_level got %0d want 1", level); end
      tick();
      n_checks++; if (bus.ack !== 1'b1) begin n_fail++; $display("FAIL lat_ack got %0h want 1", bus.ack); end
      n_checks++; if (bus.dout !== 32'h5) begin n_fail++; $display("FAIL lat_dout got %0h want 5", bus.dout); end
      n_checks++; if (count !== 32'd1) begin n_fail++; $display("FAIL lat_count got %0d want 1", count); end
      tick();
      n_checks++; if (bus.ack !== 1'b0) begin n_fail++; $display("FAIL lat_ack_drop got %0h want 0", bus.ack); end
      n_checks++; if (bus.dout !== 32'h5) begin n_fail++; $display("FAIL lat_dout_hold got %0h want 5", bus.dout); end
      bus.req = 1'b0;
      tick();
   endtask

   task automatic test_throughput();
      int n_ack;
      logic prev_ack;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      for (int i = 0; i < 8; i++) begin
         bus.s_valid = 1'b1; bus.s_data = 32'h100 + i;
         tick();
      end
      bus.s_valid = 1'b0;
      n_checks++; if (level !== 4'd8) begin n_fail++; $display("FAIL thr_preload got %0d want 8", level); end
      bus.req = 1'b1;
      n_ack = 0;
      prev_ack = 1'b0;
      for (int c = 0; c < 16; c++) begin
         tick();
         if (bus.ack === 1'b1) begin
            n_checks++;
            if (bus.dout !== 32'h100 + n_ack) begin
               n_fail++; $display("FAIL thr_data got %0h want %0h", bus.dout, 32'h100 + n_ack);
            end
            n_checks++;
            if (prev_ack) begin n_fail++; $display("FAIL thr_b2b_ack got 1 want 0 at cycle %0d", c); end
            n_ack++;
         end
         prev_ack = bus.ack;
      end
      bus.req = 1'b0;
      n_checks++; if (n_ack != 8) begin n_fail++; $display("FAIL thr_nack got %0d want 8", n_ack); end
      n_checks++; if (count !== 32'd8) begin n_fail++; $display("FAIL thr_count got %0d want 8", count); end
      n_checks++; if (level !== 4'd0) begin n_fail++; $display("FAIL thr_level got %0d want 0", level); end
      tick();
   endtask

   task automatic test_full();
      for (int i = 0; i < 8; i++) begin
         bus.s_valid = 1'b1; bus.s_data = 32'h200 + i;
         tick();
      end
      n_checks++; if (bus.s_ready !== 1'b0) begin n_fail++; $display("FAIL full_sready got %0h want 0", bus.s_ready); end
      n_checks++; if (level !== 4'd8) begin n_fail++; $display("FAIL full_level got %0d want 8", level); end
      bus.s_data = 32'h2FF;
      tick();
      bus.s_valid = 1'b0;
      n_checks++; if (level !== 4'd8) begin n_fail++; $display("FAIL full_9th got %0d want 8", level); end
      bus.req = 1'b1;
      tick();
      bus.req = 1'b0;
      n_checks++; if (bus.ack !== 1'b1 || bus.dout !== 32'h200) begin
         n_fail++; $display("FAIL full_pop got ack=%0h dout=%0h want ack=1 dout=200", bus.ack, bus.dout);
      end
      n_checks++; if (bus.s_ready !== 1'b1) begin n_fail++; $display("FAIL full_sready_back got %0h want 1", bus.s_ready); end
      n_checks++; if (level !== 4'd7) begin n_fail++; $display("FAIL full_level7 got %0d want 7", level); end
      bus.req = 1'b1;
      for (int c = 0; c < 14; c++) tick();
      bus.req = 1'b0;
      n_checks++; if (bus.dout !== 32'h207) begin n_fail++; $display("FAIL full_last got %0h want 207", bus.dout); end
      n_checks++; if (level !== 4'd0) begin n_fail++; $display("FAIL full_drain got %0d want 0", level); end
      n_checks++; if (count !== 32'd16) begin n_fail++; $display("FAIL full_count got %0d want 16", count); end
      tick();
   endtask

   task automatic test_push_pop();
      bus.s_valid = 1'b1; bus.s_data = 32'h31;
      tick();
      bus.s_data = 32'h32; bus.req = 1'b1;
      tick();
      bus.s_valid = 1'b0; bus.req = 1'b0;
      n_checks++; if (level !== 4'd1) begin n_fail++; $display("FAIL pp_level got %0d want 1", level); end
      n_checks++; if (bus.ack !== 1'b1 || bus.dout !== 32'h31) begin
         n_fail++; $display("FAIL pp_ack got ack=%0h dout=%0h want ack=1 dout=31", bus.ack, bus.dout);
      end
      bus.req = 1'b1;
      tick();
      tick();
      bus.req = 1'b0;
      n_checks++; if (bus.dout !== 32'h32) begin n_fail++; $display("FAIL pp_second got %0h want 32", bus.dout); end
      tick();
   endtask

   task automatic test_empty_req();
      int n_ack;
      n_ack = 0;
      bus.req = 1'b1;
      for (int c = 0; c < 10; c++) begin
         tick();
         if (bus.ack === 1'b1) n_ack++;
      end
      n_checks++; if (n_ack != 0) begin n_fail++; $display("FAIL empty_noack got %0d acks want 0", n_ack); end
      bus.s_valid = 1'b1; bus.s_data = 32'hA;
      tick();
      bus.s_valid = 1'b0;
      tick();
      n_checks++; if (bus.ack !== 1'b1 || bus.dout !== 32'hA) begin
         n_fail++; $display("FAIL empty_ack got ack=%0h dout=%0h want ack=1 dout=a", bus.ack, bus.dout);
      end
      n_ack = 0;
      for (int c = 0; c < 4; c++) begin
         tick();
         if (bus.ack === 1'b1) n_ack++;
      end
      n_checks++; if (n_ack != 0) begin n_fail++; $display("FAIL empty_single got %0d extra acks want 0", n_ack); end
      bus.req = 1'b0;
      tick();
   endtask

   task automatic test_flush();
      logic [DW-1:0] words [3];
      logic [DW-1:0] want  [3];
      int n_ack;
      int n_extra;
      words[0] = 32'h3;  words[1] = 32'hA;  words[2] = 32'h7F;
      want[0]  = 32'hB;  want[1]  = 32'h19; want[2]  = 32'h103;
      for (int i = 0; i < 3; i++) begin
         bus.s_valid = 1'b1; bus.s_data = 32'h41 + i;
         tick();
      end
      n_checks++; if (level !== 4'd3) begin n_fail++; $display("FAIL fl_pre_level got %0d want 3", level); end
      flush = 1'b1; bus.s_data = 32'h99;
      tick();
      flush = 1'b0; bus.s_valid = 1'b0;
      n_checks++; if (level !== 4'd0) begin n_fail++; $display("FAIL fl_level got %0d want 0", level); end
      n_checks++; if (count !== 32'd0) begin n_fail++; $display("FAIL fl_count got %0d want 0", count); end
      n_checks++; if (bus.dout !== INIT) begin n_fail++; $display("FAIL fl_dout got %0h want %0h", bus.dout, INIT); end
      n_extra = 0;
      bus.req = 1'b1;
      for (int c = 0; c < 4; c++) begin
         tick();
         if (bus.ack === 1'b1) n_extra++;
      end
      n_checks++; if (n_extra != 0) begin n_fail++; $display("FAIL fl_dropped got %0d acks want 0", n_extra); end
      // Pipeline in -> addi(+5) -> add(with in): consumer output = 2*x + 5.
      bus.req = 1'b0;
      for (int i = 0; i < 3; i++) begin
         bus.s_valid = 1'b1; bus.s_data = words[i];
         tick();
      end
      bus.s_valid = 1'b0;
      bus.req = 1'b1;
      n_ack = 0;
      for (int c = 0; c < 20 && n_ack < 3; c++) begin
         tick();
         if (bus.ack === 1'b1) begin
            n_checks++;
            if (((bus.dout + 32'd5) + bus.dout) !== want[n_ack]) begin
               n_fail++;
               $display("FAIL fl_pipe got %0h want %0h", (bus.dout + 32'd5) + bus.dout, want[n_ack]);
            end
            n_ack++;
         end
      end
      bus.req = 1'b0;
      n_checks++; if (n_ack != 3) begin n_fail++; $display("FAIL fl_pipe_timeout got %0d acks want 3", n_ack); end
      n_checks++; if (count !== 32'd3) begin n_fail++; $display("FAIL fl_pipe_count got %0d want 3", count); end
      tick();
   endtask

   initial begin
      n_checks    = 0;
      n_fail      = 0;
      rst         = 1'b0;
      flush       = 1'b0;
      bus.s_valid = 1'b0;
      bus.s_data  = '0;
      bus.req     = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
      test_reset();
      test_latency();
      test_throughput();
      test_full();
      test_push_pop();
      test_empty_req();
      test_flush();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
